sevenseg_mux_n: RTL

Parametrised multiplexed seven-segment display driver and the successor to the fixed 4-digit stopwatch display logic. It converts a binary value to BCD sequentially (double-dabble) and time-multiplexes N digits. It supports per-digit blinking, decimal points, leading-zero blanking and overflow indication. It sits between the counter/control logic and the board's seg/an pins.

---
 rtl/sevenseg_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 rtl/sevenseg_mux_n.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Contents: active-low glyphs for 0..9, blank and dash glyphs, the 10^N helper
// used for the overflow limit, and the converter FSM state encoding.
package sevenseg_pkg;

  // Segment byte layout: bit 7 = dp, bits 6:0 = g..a, all active-low.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Glyphs indexed by decimal digit; entry 0 is the rightmost byte.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Converter FSM states, kept as plain constants for older tool flows.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_SHIFT  = 2'd1;
  localparam fsm_state_t ST_COMMIT = 2'd2;

  // 10^n, used at elaboration time for the overflow threshold.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Map a BCD nibble to its glyph; non-decimal codes render blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] g;
    g = SEG_BLANK;
    if (nib <= 4'd9) begin
      g = SEG_DIGITS[nib];
    end
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble) with display registers.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_value        binary value captured on an accepted load
//   i_load         single-cycle start pulse, ignored while busy
//   o_busy         high from the cycle after capture through COMMIT
//   o_bcd          committed BCD digits, nibble 0 = least significant
//   o_overflow     committed flag: captured value was >= 10^NUM_DIGITS
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned VALUE_W    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [VALUE_W-1:0]      i_value,
  input  logic                    i_load,
  output logic                    o_busy,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  fsm_state_t         r_state;
  fsm_state_t         w_state_nxt;
  logic [VALUE_W-1:0] r_shift;
  logic [BCD_W-1:0]   r_acc;
  logic [BCD_W-1:0]   w_acc_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_cap;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_busy;
  logic               w_last_shift;

  assign w_last_shift = (r_cnt == CNT_W'(VALUE_W - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_load) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (w_last_shift) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Add-3 correction per nibble; the 4-bit add wraps so nothing carries
  // into the neighbouring nibble.
  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Capture, shift and commit datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_shift   <= i_value;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= (64'(i_value) >= OVF_LIMIT);
            r_busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Top bit of the accumulator falls off: only reachable on overflow.
          r_acc   <= {w_acc_adj[BCD_W-2:0], r_shift[VALUE_W-1]};
          r_shift <= {r_shift[VALUE_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_COMMIT: begin
          r_bcd  <= r_acc;
          r_ovf  <= r_ovf_cap;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/sevenseg_mux_n.sv
// Multiplexed N-digit seven-segment display driver.
// Ports:
//   msclk, rst     clock and synchronous active-high reset
//   value, load    binary value and start pulse for a new conversion
//   enable         0 blanks every digit; dividers keep running
//   blink_mask     per-digit blink enable
//   dp_mask        per-digit decimal point
//   lz_blank       leading-zero blanking enable
//   seg            active-low segments, seg[7]=dp, seg[6:0]=g..a (registered)
//   an             active-low one-hot anode, an[0]=rightmost (registered)
//   busy           conversion in progress
//   overflow       last committed value was >= 10^NUM_DIGITS
module sevenseg_mux_n
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned VALUE_W     = 14,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                  msclk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lz_blank,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCD_W-1:0]      w_bcd;
  logic                  w_ovf;
  logic                  w_busy;

  logic [REF_W-1:0]      r_ref_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BLK_W-1:0]      r_blk_cnt;
  logic                  r_phase;
  logic                  w_ref_tc;
  logic                  w_blk_tc;

  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [3:0]            w_nib;
  logic [7:0]            w_glyph;
  logic                  w_blank;
  logic [7:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_bin2bcd (
    .i_clk      (msclk),
    .i_rst      (rst),
    .i_value    (value),
    .i_load     (load),
    .o_busy     (w_busy),
    .o_bcd      (w_bcd),
    .o_overflow (w_ovf)
  );

  assign w_ref_tc = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));
  assign w_blk_tc = (r_blk_cnt == BLK_W'(BLINK_DIV - 1));

  // Scan divider and digit index.
  always_ff @(posedge msclk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else if (w_ref_tc) begin
      r_ref_cnt <= '0;
      if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // Blink divider; phase 1 means blinking digits are visible.
  always_ff @(posedge msclk) begin
    if (rst) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b1;
    end else if (w_blk_tc) begin
      r_blk_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + BLK_W'(1);
    end
  end

  // w_zero_from[i]: every committed digit at position >= i is zero.
  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_zero_from = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      v_run          = v_run & (w_bcd[4*i +: 4] == 4'd0);
      w_zero_from[i] = v_run;
    end
  end

  // Pick the scanned digit and decide what it shows.
  always_comb begin
    w_nib   = w_bcd[{r_idx, 2'b00} +: 4];
    w_glyph = w_ovf ? SEG_DASH : seg_encode(w_nib);
    w_blank = ~enable
            | (blink_mask[r_idx] & ~r_phase)
            | (~w_ovf & lz_blank & (r_idx != '0) & w_zero_from[r_idx]);
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = '1;
    if (!w_blank) begin
      w_seg_nxt = {~dp_mask[r_idx], w_glyph[6:0]};
      w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  // Registered pin drivers.
  always_ff @(posedge msclk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign busy     = w_busy;
  assign overflow = w_ovf;

endmodule
